// File: rtl/mc_mem_responder.sv
// rtl/mc_mem_responder.sv - wait-state memory responder for the multicycle MIPS datapath
//
// Serves read/write strobes against an internal word-organised RAM with a
// programmable latency and byte/half/word lanes.
//
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_mem_read       read request (level, sampled in IDLE)
//   i_mem_write      write request (level, sampled in IDLE)
//   i_addr           byte address; word index = i_addr[ADDR_WIDTH+1:2]
//   i_write_data     right-aligned store data
//   i_size           00 byte, 01 half, 10 word, 11 illegal
//   i_unsigned       zero-extend byte/half reads when 1
//   o_mem_data       read result, held until the next successful read
//   o_mem_ready      one-cycle completion pulse
//   o_mem_busy       request in flight
//   o_addr_err       one-cycle error pulse, coincident with o_mem_ready
module mc_mem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_write_data,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_mem_data,
   output logic        o_mem_ready,
   output logic        o_mem_busy,
   output logic        o_addr_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [1:0]            r_lane;
   logic [31:0]           r_wdata;
   logic [1:0]            r_size;
   logic                  r_uns;
   logic                  r_wr;
   logic                  r_err;
   logic [31:0]           r_mem [DEPTH];

   logic                  w_idle;
   logic                  w_req;
   logic                  w_in_err;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [1:0]            w_lane;
   logic [31:0]           w_wdata;
   logic [1:0]            w_size;
   logic                  w_uns;
   logic                  w_wr;
   logic                  w_err;
   logic                  w_go_resp;
   logic [31:0]           w_word;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [31:0]           w_rdata;
   logic [31:0]           w_merge;
   logic                  w_unused_addr;

   assign w_unused_addr = ^i_addr[31:ADDR_WIDTH+2];

   assign w_idle   = (r_state == S_IDLE);
   assign w_req    = i_mem_read | i_mem_write;
   assign w_in_err = (i_mem_read & i_mem_write) | (i_size == 2'b11) |
                     ((i_size == 2'b01) & i_addr[0]) |
                     ((i_size == 2'b10) & (i_addr[1:0] != 2'b00));

   // The access completes on the edge that enters RESP. With LATENCY=1 that is
   // the sample edge itself, so the live inputs stand in for the latched copy.
   assign w_idx   = w_idle ? i_addr[ADDR_WIDTH+1:2] : r_idx;
   assign w_lane  = w_idle ? i_addr[1:0]            : r_lane;
   assign w_wdata = w_idle ? i_write_data           : r_wdata;
   assign w_size  = w_idle ? i_size                 : r_size;
   assign w_uns   = w_idle ? i_unsigned             : r_uns;
   assign w_wr    = w_idle ? (i_mem_write & ~i_mem_read) : r_wr;
   assign w_err   = w_idle ? w_in_err               : r_err;

   assign w_go_resp = (w_idle && w_req && (LATENCY == 1)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd1));

   always_comb begin
      w_word  = r_mem[w_idx];
      w_byte  = w_word[{w_lane, 3'b000} +: 8];
      w_half  = w_lane[1] ? w_word[31:16] : w_word[15:0];
      w_rdata = w_word;
      w_merge = w_wdata;
      case (w_size)
         2'b00: begin
            w_rdata = w_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            w_merge = w_word;
            w_merge[{w_lane, 3'b000} +: 8] = w_wdata[7:0];
         end
         2'b01: begin
            w_rdata = w_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            w_merge = w_word;
            w_merge[{w_lane[1], 4'b0000} +: 16] = w_wdata[15:0];
         end
         default: begin
            w_rdata = w_word;
            w_merge = w_wdata;
         end
      endcase
   end

   // RAM is never reset; a reset on the commit edge discards the pending write.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && w_go_resp && w_wr && !w_err) begin
         r_mem[w_idx] <= w_merge;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_idx       <= '0;
         r_lane      <= 2'b00;
         r_wdata     <= 32'd0;
         r_size      <= 2'b00;
         r_uns       <= 1'b0;
         r_wr        <= 1'b0;
         r_err       <= 1'b0;
         o_mem_data  <= 32'd0;
         o_mem_ready <= 1'b0;
         o_mem_busy  <= 1'b0;
         o_addr_err  <= 1'b0;
      end else begin
         o_mem_ready <= 1'b0;
         o_addr_err  <= 1'b0;
         if (w_go_resp) begin
            o_mem_ready <= 1'b1;
            o_addr_err  <= w_err;
            if (!w_wr && !w_err) begin
               o_mem_data <= w_rdata;
            end
         end
         case (r_state)
            S_IDLE: begin
               // Busy stays up through the IDLE cycle after RESP, so it covers
               // the full LATENCY+1 access slot.
               o_mem_busy <= w_req;
               if (w_req) begin
                  r_idx   <= i_addr[ADDR_WIDTH+1:2];
                  r_lane  <= i_addr[1:0];
                  r_wdata <= i_write_data;
                  r_size  <= i_size;
                  r_uns   <= i_unsigned;
                  r_wr    <= i_mem_write & ~i_mem_read;
                  r_err   <= w_in_err;
                  r_cnt   <= 4'(LATENCY - 1);
                  r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               o_mem_busy <= 1'b1;
               r_cnt      <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= S_RESP;
               end
            end
            default: begin
               o_mem_busy <= 1'b1;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_mem_responder.sv
// tb/tb_mc_mem_responder.sv - self-checking bench for mc_mem_responder
module tb_mc_mem_responder;

   logic        clk;
   logic        rst_n;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  size;
   logic        uns;

   logic [31:0] data2, data1, data5;
   logic        rdy2, rdy1, rdy5;
   logic        busy2, busy1, busy5;
   logic        err2, err1, err5;

   int n_cmp = 0;
   int n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mc_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(rd), .i_mem_write(wr),
      .i_addr(addr), .i_write_data(wdata), .i_size(size), .i_unsigned(uns),
      .o_mem_data(data2), .o_mem_ready(rdy2), .o_mem_busy(busy2), .o_addr_err(err2));

   mc_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(rd), .i_mem_write(wr),
      .i_addr(addr), .i_write_data(wdata), .i_size(size), .i_unsigned(uns),
      .o_mem_data(data1), .o_mem_ready(rdy1), .o_mem_busy(busy1), .o_addr_err(err1));

   mc_mem_responder #(.ADDR_WIDTH(8), .LATENCY(5)) dut5 (
      .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(rd), .i_mem_write(wr),
      .i_addr(addr), .i_write_data(wdata), .i_size(size), .i_unsigned(uns),
      .o_mem_data(data5), .o_mem_ready(rdy5), .o_mem_busy(busy5), .o_addr_err(err5));

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One access on the selected instance; returns the cycle (1-based, after the
   // sample edge) holding the ready pulse and the number of busy cycles.
   task automatic access(input int sel, input logic a_rd, input logic a_wr,
                         input logic [31:0] a_addr, input logic [31:0] a_wd,
                         input logic [1:0] a_sz, input logic a_un,
                         output int lat, output int bcnt,
                         output logic [31:0] dat, output logic er);
      logic b, r;
      lat = 0; bcnt = 0; dat = 32'd0; er = 1'b0;
      @(negedge clk);
      rd = a_rd; wr = a_wr; addr = a_addr; wdata = a_wd; size = a_sz; uns = a_un;
      @(posedge clk);
      #1;
      rd = 1'b0; wr = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         b = (sel == 1) ? busy1 : (sel == 5) ? busy5 : busy2;
         r = (sel == 1) ? rdy1  : (sel == 5) ? rdy5  : rdy2;
         if (b) bcnt++;
         if (r && lat == 0) begin
            lat = k;
            dat = (sel == 1) ? data1 : (sel == 5) ? data5 : data2;
            er  = (sel == 1) ? err1  : (sel == 5) ? err5  : err2;
         end
         if (!b) break;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int          lat, bcnt, nrdy;
      logic [31:0] dat;
      logic        er;

      vecs[0]  = '{"sw_10",       0, 1, 32'h10,  32'hDEADBEEF, 2'b10, 0, 32'h00000000, 0};
      vecs[1]  = '{"lw_10",       1, 0, 32'h10,  32'h0,        2'b10, 0, 32'hDEADBEEF, 0};
      vecs[2]  = '{"sw_20",       0, 1, 32'h20,  32'h80F07F12, 2'b10, 0, 32'hDEADBEEF, 0};
      vecs[3]  = '{"lb_22",       1, 0, 32'h22,  32'h0,        2'b00, 0, 32'hFFFFFFF0, 0};
      vecs[4]  = '{"lbu_22",      1, 0, 32'h22,  32'h0,        2'b00, 1, 32'h000000F0, 0};
      vecs[5]  = '{"lh_22",       1, 0, 32'h22,  32'h0,        2'b01, 0, 32'hFFFF80F0, 0};
      vecs[6]  = '{"lhu_20",      1, 0, 32'h20,  32'h0,        2'b01, 1, 32'h00007F12, 0};
      vecs[7]  = '{"sw_30",       0, 1, 32'h30,  32'h11223344, 2'b10, 0, 32'h00007F12, 0};
      vecs[8]  = '{"sb_31",       0, 1, 32'h31,  32'h000000AA, 2'b00, 0, 32'h00007F12, 0};
      vecs[9]  = '{"lw_30_a",     1, 0, 32'h30,  32'h0,        2'b10, 0, 32'h1122AA44, 0};
      vecs[10] = '{"sh_32",       0, 1, 32'h32,  32'h0000BEEF, 2'b01, 0, 32'h1122AA44, 0};
      vecs[11] = '{"lw_30_b",     1, 0, 32'h30,  32'h0,        2'b10, 0, 32'hBEEFAA44, 0};
      vecs[12] = '{"err_lw_05",   1, 0, 32'h05,  32'h0,        2'b10, 0, 32'hBEEFAA44, 1};
      vecs[13] = '{"err_sh_07",   0, 1, 32'h07,  32'h0000FFFF, 2'b01, 0, 32'hBEEFAA44, 1};
      vecs[14] = '{"err_size11",  0, 1, 32'h30,  32'h55555555, 2'b11, 0, 32'hBEEFAA44, 1};
      vecs[15] = '{"err_both",    1, 1, 32'h30,  32'h00000000, 2'b10, 0, 32'hBEEFAA44, 1};
      vecs[16] = '{"lw_30_after", 1, 0, 32'h30,  32'h0,        2'b10, 1, 32'hBEEFAA44, 0};
      vecs[17] = '{"lb_33",       1, 0, 32'h33,  32'h0,        2'b00, 0, 32'hFFFFFFBE, 0};
      vecs[18] = '{"lh_30",       1, 0, 32'h30,  32'h0,        2'b01, 0, 32'hFFFFAA44, 0};
      vecs[19] = '{"lbu_11",      1, 0, 32'h11,  32'h0,        2'b00, 1, 32'h000000BE, 0};
      vecs[20] = '{"lw_wrap_410", 1, 0, 32'h410, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0};
      vecs[21] = '{"lhu_32",      1, 0, 32'h32,  32'h0,        2'b01, 1, 32'h0000BEEF, 0};

      rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; size = 2'b10; uns = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data",  data2, 32'd0);
      chk("reset_ready", {31'd0, rdy2},  32'd0);
      chk("reset_busy",  {31'd0, busy2}, 32'd0);
      chk("reset_err",   {31'd0, err2},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         access(2, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].size, vecs[i].uns, lat, bcnt, dat, er);
         chk({vecs[i].name, "_lat"},  lat,  32'd2);
         chk({vecs[i].name, "_busy"}, bcnt, 32'd3);
         chk({vecs[i].name, "_err"},  {31'd0, er}, {31'd0, vecs[i].exp_err});
         chk({vecs[i].name, "_data"}, data2, vecs[i].exp_data);
      end

      // Read strobe re-asserted across the WAIT->RESP edge must not be queued.
      nrdy = 0;
      @(negedge clk);
      rd = 1'b1; wr = 1'b0; addr = 32'h10; size = 2'b10; uns = 1'b0;
      @(posedge clk);
      #1;
      if (rdy2) nrdy++;
      @(posedge clk);
      #1;
      rd = 1'b0;
      if (rdy2) nrdy++;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (rdy2) nrdy++;
      end
      chk("wait_strobe_ready_count", nrdy, 32'd1);
      chk("wait_strobe_data", data2, 32'hDEADBEEF);

      repeat (10) @(posedge clk);
      access(1, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, lat, bcnt, dat, er);
      chk("lat1_lat",  lat,  32'd1);
      chk("lat1_busy", bcnt, 32'd2);
      chk("lat1_data", dat,  32'hDEADBEEF);

      repeat (10) @(posedge clk);
      access(5, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, lat, bcnt, dat, er);
      chk("lat5_lat",  lat,  32'd5);
      chk("lat5_busy", bcnt, 32'd6);
      chk("lat5_data", dat,  32'hDEADBEEF);

      // Reset during WAIT aborts a pending store.
      repeat (10) @(posedge clk);
      access(2, 1'b0, 1'b1, 32'h40, 32'h0, 2'b10, 1'b0, lat, bcnt, dat, er);
      chk("clr_40_lat", lat, 32'd2);
      @(negedge clk);
      wr = 1'b1; rd = 1'b0; addr = 32'h40; wdata = 32'h12345678; size = 2'b10;
      @(posedge clk);
      #1;
      wr = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_data",  data2, 32'd0);
      chk("rst_mid_ready", {31'd0, rdy2},  32'd0);
      chk("rst_mid_busy",  {31'd0, busy2}, 32'd0);
      chk("rst_mid_err",   {31'd0, err2},  32'd0);
      rst_n = 1'b1;
      nrdy = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (rdy2) nrdy++;
      end
      chk("rst_mid_no_ready", nrdy, 32'd0);
      access(2, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, lat, bcnt, dat, er);
      chk("rst_mid_lw40_lat",  lat, 32'd2);
      chk("rst_mid_lw40_data", dat, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
